ddr_rd_stream: RTL and testbench
================================

DDR_RD_STREAM -- requirements
Module: ddr_rd_stream

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- FIFO_DEPTH, 32, data FIFO entries (power of 2)
- MAX_BURST, 16, max DDR words per read request
- AXI_ADDR_W, 32, DDR byte-address width
- DDR_W, from GLOBAL_PARAM, DDR data width
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, single clock
- rst, in, 1, synchronous active-high reset
- start, in, 1, one-cycle launch pulse
- done, out, 1, one-cycle pulse when the last word is accepted downstream
- conf_addr, in, AXI_ADDR_W, DDR start byte address, sampled on start
- conf_trans_num, in, 8, DDR words to fetch, sampled on start
- ddr_rd_req, out, 1, read request valid
- ddr_rd_gnt, in, 1, request accepted when req & gnt
- ddr_rd_addr, out, AXI_ADDR_W, burst byte address
- ddr_rd_len, out, 4, burst length minus 1
- ddr_rd_data, in, DDR_W, returned read data
- ddr_rd_valid, in, 1, read data strobe (no backpressure)
- ddr_data, out, DDR_W, stream data to the buffer loader
- ddr_valid, out, 1, stream valid
- ddr_ready, in, 1, stream ready

Function
REQ-003 FSM states SHALL be IDLE, REQ, DRAIN; start in IDLE latches config, clears counters, and goes to REQ (trans_num 0: done pulse next cycle, stay IDLE).
REQ-004 start outside IDLE SHALL be ignored.
REQ-005 Burst length L SHALL be min(words remaining to request, MAX_BURST); ddr_rd_len = L-1.
REQ-006 Credit: free = FIFO_DEPTH - fifo_count - outstanding; ddr_rd_req SHALL assert only when free >= L, registered output.
REQ-007 ddr_rd_req, ddr_rd_addr, ddr_rd_len SHALL hold stable until req & gnt; no retraction.
REQ-008 On req & gnt: outstanding += L, addr += L*(DDR_W/8) wrapping modulo 2^AXI_ADDR_W, remaining -= L; the next request SHALL not issue earlier than the following cycle.
REQ-009 When remaining reaches 0 the FSM SHALL go REQ->DRAIN; DRAIN->IDLE when all conf_trans_num words have been accepted downstream, with done = 1 that cycle's successor (one pulse).
REQ-010 Each ddr_rd_valid SHALL write ddr_rd_data into the FIFO and decrement outstanding; the credit rule guarantees no overflow; a write while full SHALL be dropped and flagged by a simulation assertion.
REQ-011 FIFO SHALL be first-word-fall-through: ddr_valid = !empty, ddr_data = head entry; pop on ddr_valid & ddr_ready.
REQ-012 Simultaneous push and pop SHALL keep fifo_count unchanged, legal at full and empty; push into empty SHALL give ddr_valid the next cycle (1-cycle latency).
REQ-013 Simultaneous grant and ddr_rd_valid SHALL update outstanding by +L-1 in one cycle.
REQ-014 Word order out SHALL equal DDR address order; no reordering, no duplication.
REQ-015 ddr_ready low SHALL stall output indefinitely without losing data; requests resume once credit frees.

Reset
REQ-016 rst SHALL force IDLE, FIFO empty, outstanding 0, ddr_rd_req 0, ddr_valid 0, done 0, ddr_rd_addr 0, ddr_rd_len 0, and takes priority over start.
REQ-017 rst mid-transfer SHALL abandon the transfer with no done pulse; the interconnect must be quiesced externally, and late read data after reset SHALL be discarded by the FIFO.

Verification
REQ-018 Bench SHALL cover:
- conf_addr 0x1000, trans_num 40, gnt always 1, ddr_ready 1 -> bursts (0x1000, len 15), (0x1000+16*DDR_W/8, len 15), (+32*DDR_W/8, len 7); 40 words in order; one done.
- trans_num 40, ddr_ready 0 -> exactly 32 words requested, then ddr_rd_req held 0; FIFO fills to 32 with ddr_valid 1; raising ready resumes and completes 40.
- trans_num 0 -> no ddr_rd_req; done pulse one cycle after start.
- gnt delayed 5 cycles -> addr and len stable throughout; start pulsed while busy -> ignored.
- ddr_rd_valid coincident with gnt and with pop at full count -> outstanding and fifo_count exact; no loss.
- rst asserted after 10 of 40 words -> outputs at reset values next cycle; a new start with trans_num 3 completes correctly.

Source files
------------

// File: rtl/ddr_rd_stream.sv
// ddr_rd_stream: fetches conf_trans_num DDR words in credit-limited bursts and
// streams them, in address order, through a first-word-fall-through FIFO.
module ddr_rd_stream #(
    parameter int FIFO_DEPTH = 32,
    parameter int MAX_BURST  = 16,
    parameter int AXI_ADDR_W = 32,
    parameter int DDR_W      = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  done,
    input  logic [AXI_ADDR_W-1:0] conf_addr,
    input  logic [7:0]            conf_trans_num,
    output logic                  ddr_rd_req,
    input  logic                  ddr_rd_gnt,
    output logic [AXI_ADDR_W-1:0] ddr_rd_addr,
    output logic [3:0]            ddr_rd_len,
    input  logic [DDR_W-1:0]      ddr_rd_data,
    input  logic                  ddr_rd_valid,
    output logic [DDR_W-1:0]      ddr_data,
    output logic                  ddr_valid,
    input  logic                  ddr_ready
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int LW = $clog2(MAX_BURST) + 1;
    localparam logic [AXI_ADDR_W-1:0] BYTES = AXI_ADDR_W'(DDR_W / 8);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] REQ   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]            state;
    logic [AXI_ADDR_W-1:0] next_addr;
    logic [7:0]            remaining;
    logic [7:0]            total;
    logic [7:0]            popped;
    logic [CW-1:0]         outstanding;
    logic [CW-1:0]         fifo_count;
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [DDR_W-1:0]      mem [FIFO_DEPTH];

    logic [LW-1:0]         burst_len;
    logic [CW:0]           free_cnt;
    logic                  can_issue;
    logic                  grant;
    logic                  rd_accept;
    logic                  fifo_full;
    logic                  push;
    logic                  pop;
    logic                  last_pop;

    assign ddr_valid = (fifo_count != '0);
    assign ddr_data  = mem[rd_ptr];

    // Burst sizing, credit and handshake decode
    always_comb begin
        burst_len = (32'(remaining) >= 32'(MAX_BURST)) ? LW'(MAX_BURST) : LW'(remaining);
        free_cnt  = (CW+1)'(FIFO_DEPTH) - {1'b0, fifo_count} - {1'b0, outstanding};
        can_issue = (state == REQ) && !ddr_rd_req && (remaining != 8'd0) &&
                    (32'(free_cnt) >= 32'(burst_len));
        grant     = ddr_rd_req && ddr_rd_gnt;
        // Beats arriving with nothing outstanding are stale (pre-reset) and ignored.
        rd_accept = ddr_rd_valid && (outstanding != '0);
        fifo_full = (fifo_count == CW'(FIFO_DEPTH));
        push      = rd_accept && (!fifo_full || pop);
        pop       = ddr_valid && ddr_ready;
        last_pop  = pop && (state == DRAIN) && ((popped + 8'd1) == total);
    end

    // Transfer FSM, request issue and done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            done        <= 1'b0;
            next_addr   <= '0;
            remaining   <= '0;
            total       <= '0;
            popped      <= '0;
            ddr_rd_req  <= 1'b0;
            ddr_rd_addr <= '0;
            ddr_rd_len  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (conf_trans_num == 8'd0) begin
                            done <= 1'b1;
                        end else begin
                            state     <= REQ;
                            next_addr <= conf_addr;
                            remaining <= conf_trans_num;
                            total     <= conf_trans_num;
                            popped    <= '0;
                        end
                    end
                end
                REQ: begin
                    if (pop) popped <= popped + 8'd1;
                    if (can_issue) begin
                        ddr_rd_req  <= 1'b1;
                        ddr_rd_addr <= next_addr;
                        ddr_rd_len  <= 4'(burst_len - LW'(1));
                    end
                    if (grant) begin
                        ddr_rd_req <= 1'b0;
                        next_addr  <= next_addr + AXI_ADDR_W'(burst_len) * BYTES;
                        remaining  <= remaining - 8'(burst_len);
                        if (remaining == 8'(burst_len)) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop) popped <= popped + 8'd1;
                    if (last_pop) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outstanding-beat and FIFO occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding <= '0;
            fifo_count  <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            outstanding <= outstanding + (grant ? CW'(burst_len) : '0) -
                           (rd_accept ? CW'(1) : '0);
            if (push && !pop) fifo_count <= fifo_count + CW'(1);
            else if (pop && !push) fifo_count <= fifo_count - CW'(1);
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
        end
    end

    // FIFO storage, written on every accepted read beat
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= ddr_rd_data;
    end

    // A beat that finds the FIFO full with no pop would be lost; credit gating must prevent it.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(rd_accept && fifo_full && !pop));

endmodule

// File: tb/tb_ddr_rd_stream.sv
// tb_ddr_rd_stream: randomized traffic against a cycle-level behavioural model of
// the read streamer (credit, burst sizing, address order, FWFT occupancy, done).
module tb_ddr_rd_stream;

    localparam int DEPTH = 32;
    localparam int MAXB  = 16;
    localparam int BYTES = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        done;
    logic [31:0] conf_addr;
    logic [7:0]  conf_trans_num;
    logic        ddr_rd_req;
    logic        ddr_rd_gnt = 1'b0;
    logic [31:0] ddr_rd_addr;
    logic [3:0]  ddr_rd_len;
    logic [63:0] ddr_rd_data = '0;
    logic        ddr_rd_valid = 1'b0;
    logic [63:0] ddr_data;
    logic        ddr_valid;
    logic        ddr_ready = 1'b0;

    ddr_rd_stream #(
        .FIFO_DEPTH(DEPTH),
        .MAX_BURST (MAXB),
        .AXI_ADDR_W(32),
        .DDR_W     (64)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .done          (done),
        .conf_addr     (conf_addr),
        .conf_trans_num(conf_trans_num),
        .ddr_rd_req    (ddr_rd_req),
        .ddr_rd_gnt    (ddr_rd_gnt),
        .ddr_rd_addr   (ddr_rd_addr),
        .ddr_rd_len    (ddr_rd_len),
        .ddr_rd_data   (ddr_rd_data),
        .ddr_rd_valid  (ddr_rd_valid),
        .ddr_data      (ddr_data),
        .ddr_valid     (ddr_valid),
        .ddr_ready     (ddr_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Traffic knobs set by the scenario process
    int gnt_delay = 0;
    int rdv_pct   = 100;
    int rdy_pct   = 100;

    // Behavioural model state
    logic        m_busy = 1'b0;
    int          m_total = 0;
    logic [31:0] m_base = '0;
    logic [31:0] m_addr = '0;
    int          m_rem = 0;
    int          m_popped = 0;
    int          m_fifo = 0;
    int          m_out = 0;
    logic        exp_done = 1'b0;
    logic [31:0] pending[$];
    logic [31:0] g_addr[$];
    int          g_len[$];
    int          granted = 0;
    int          done_cnt = 0;
    int          req_cycles = 0;
    int          wcnt = 0;
    logic        prev_req = 1'b0;
    logic        prev_gnt = 1'b0;

    function automatic logic [63:0] mem_word(input logic [31:0] a);
        return {a ^ 32'h5A5A_A5A5, a};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Per-cycle compare, stimulus choice and model advance (outputs stable at negedge)
    always @(negedge clk) begin
        int          L;
        logic        busy_now;
        logic [31:0] ea;
        if (rst) begin
            m_busy = 1'b0; m_fifo = 0; m_out = 0; m_rem = 0; exp_done = 1'b0;
            wcnt = 0; prev_req = 1'b0; prev_gnt = 1'b0;
            ddr_rd_gnt = 1'b0; ddr_rd_valid = 1'b0;
        end else begin
            busy_now = m_busy;
            L = (m_rem > MAXB) ? MAXB : m_rem;
            chk("done", done, exp_done);
            if (done) done_cnt++;
            chk("valid", ddr_valid, m_fifo != 0);
            if (prev_req && !prev_gnt) chk("req_hold", ddr_rd_req, 1);
            if (ddr_rd_req) begin
                req_cycles++;
                chk("req_busy", m_busy && (m_rem > 0), 1);
                chk("req_addr", ddr_rd_addr, m_addr);
                chk("req_len", ddr_rd_len, 64'(L - 1));
                chk("req_credit", (DEPTH - m_fifo - m_out) >= L, 1);
            end
            // choose inputs for the coming edge
            if (ddr_rd_req) begin
                ddr_rd_gnt = (wcnt >= gnt_delay);
                wcnt++;
            end else begin
                ddr_rd_gnt = 1'($urandom_range(1));
            end
            if (pending.size() > 0 && $urandom_range(99) < rdv_pct) begin
                ddr_rd_valid = 1'b1;
                ddr_rd_data  = mem_word(pending.pop_front());
            end else begin
                ddr_rd_valid = 1'b0;
                ddr_rd_data  = {$urandom, $urandom};
            end
            ddr_ready = ($urandom_range(99) < rdy_pct);
            // model advance
            exp_done = 1'b0;
            if (ddr_ready && m_fifo > 0) begin
                ea = m_base + 32'(m_popped * BYTES);
                chk("data", ddr_data, mem_word(ea));
                m_popped++;
                m_fifo--;
                if (m_popped == m_total) begin
                    exp_done = 1'b1;
                    m_busy   = 1'b0;
                end
            end
            if (ddr_rd_valid && m_out > 0) begin
                m_fifo++;
                m_out--;
            end
            if (ddr_rd_req && ddr_rd_gnt) begin
                for (int k = 0; k < L; k++) pending.push_back(m_addr + 32'(k * BYTES));
                g_addr.push_back(m_addr);
                g_len.push_back(L - 1);
                m_out   += L;
                m_addr  += 32'(L * BYTES);
                m_rem   -= L;
                granted += L;
                wcnt = 0;
            end
            if (start && !busy_now) begin
                if (conf_trans_num == 8'd0) begin
                    exp_done = 1'b1;
                end else begin
                    m_busy   = 1'b1;
                    m_total  = int'(conf_trans_num);
                    m_rem    = int'(conf_trans_num);
                    m_base   = conf_addr;
                    m_addr   = conf_addr;
                    m_popped = 0;
                end
            end
            prev_req = ddr_rd_req;
            prev_gnt = ddr_rd_gnt;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [31:0] a, input logic [7:0] n);
        conf_addr = a;
        conf_trans_num = n;
        start = 1'b1;
        cycles(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int base, input int bound);
        for (int k = 0; k < bound && done_cnt == base; k++) cycles(1);
        chk(name, done_cnt > base, 1);
    endtask

    initial begin
        int base;
        int rq;
        rst = 1'b1; start = 1'b0; conf_addr = '0; conf_trans_num = '0;
        cycles(3);
        rst = 1'b0;
        chk("rst_req", ddr_rd_req, 0);
        chk("rst_valid", ddr_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_addr", ddr_rd_addr, 0);
        chk("rst_len", ddr_rd_len, 0);
        cycles(2);

        // Free-flowing 40-word transfer from 0x1000
        g_addr.delete(); g_len.delete();
        base = done_cnt;
        launch(32'h1000, 8'd40);
        wait_done("s1_done", base, 500);
        cycles(5);
        chk("s1_done_once", done_cnt, base + 1);
        chk("s1_words", m_popped, 40);
        chk("s1_nburst", g_addr.size(), 3);
        chk("s1_b0_addr", g_addr[0], 32'h1000);
        chk("s1_b0_len", g_len[0], 15);
        chk("s1_b1_addr", g_addr[1], 32'h1080);
        chk("s1_b1_len", g_len[1], 15);
        chk("s1_b2_addr", g_addr[2], 32'h1100);
        chk("s1_b2_len", g_len[2], 7);

        // Downstream stalled: credit caps requests at the FIFO depth
        rdy_pct = 0;
        granted = 0;
        base = done_cnt;
        launch(32'h4000, 8'd40);
        cycles(60);
        chk("s2_granted", granted, 32);
        chk("s2_fifo", m_fifo, 32);
        chk("s2_req_off", ddr_rd_req, 0);
        chk("s2_valid", ddr_valid, 1);
        rdy_pct = 100;
        wait_done("s2_done", base, 500);
        chk("s2_words", m_popped, 40);

        // Zero-length transfer
        cycles(3);
        rq = req_cycles;
        base = done_cnt;
        launch(32'h8000, 8'd0);
        cycles(5);
        chk("s3_done_once", done_cnt, base + 1);
        chk("s3_no_req", req_cycles, rq);

        // Slow grant, random backpressure, start pulsed while busy
        gnt_delay = 5; rdv_pct = 60; rdy_pct = 70;
        g_addr.delete(); g_len.delete();
        base = done_cnt;
        launch(32'h2000, 8'd40);
        cycles(3);
        launch(32'h0, 8'd5);
        wait_done("s4_done", base, 3000);
        cycles(5);
        chk("s4_done_once", done_cnt, base + 1);
        chk("s4_nburst", g_addr.size(), 3);
        chk("s4_words", m_popped, 40);

        // Randomized transfers, one forced across the address wrap
        for (int it = 0; it < 12; it++) begin
            logic [31:0] a;
            a = (it == 0) ? 32'hFFFF_FFC0 : $urandom;
            gnt_delay = $urandom_range(3);
            rdv_pct   = $urandom_range(100, 30);
            rdy_pct   = (it % 3 == 0) ? 100 : $urandom_range(100, 30);
            base = done_cnt;
            launch(a, 8'($urandom_range(100, 1)));
            wait_done("rnd_done", base, 5000);
            cycles(2);
        end

        // Reset mid-transfer, stale beats discarded, then a fresh 3-word run
        gnt_delay = 0; rdv_pct = 50; rdy_pct = 100;
        base = done_cnt;
        launch(32'h3000, 8'd40);
        for (int k = 0; k < 1000 && m_popped < 10; k++) cycles(1);
        chk("s6_reach10", m_popped >= 10, 1);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        chk("s6_rst_req", ddr_rd_req, 0);
        chk("s6_rst_valid", ddr_valid, 0);
        chk("s6_rst_done", done, 0);
        chk("s6_rst_addr", ddr_rd_addr, 0);
        chk("s6_rst_len", ddr_rd_len, 0);
        rdv_pct = 100;
        for (int k = 0; k < 100 && pending.size() > 0; k++) cycles(1);
        chk("s6_late_flush", pending.size(), 0);
        cycles(3);
        chk("s6_late_dropped", ddr_valid, 0);
        chk("s6_no_done", done_cnt, base);
        launch(32'h5008, 8'd3);
        wait_done("s6_done", base, 500);
        chk("s6_words", m_popped, 3);

        cycles(5);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
